// File: rtl/mem_access_pkg.sv
// Shared encodings for the memory-stage access unit: operation codes,
// effective-address modes and the sp+2 offset.
package mem_access_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_PUSH  = 2'b10,
      OP_POP   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      AM_PC    = 2'b00,
      AM_IMM   = 2'b01,
      AM_SP2   = 2'b10,
      AM_SPIMM = 2'b11
   } am_e;

   localparam int SP_INC2 = 2;

endpackage

// File: rtl/mem_access_ram.sv
// Single-port synchronous data RAM, DATA_W x 2**ADDR_W, one write enable and
// a read register that only updates when re is high (holds a stalled response).
module mem_access_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clock,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: address mux, stack pointer, registered read
// response with backpressure. Optional bounds checking via MEM_ACCESS_BOUNDS_EN.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int ADDR_W = 10,
   parameter  int NSRC   = 3,
   localparam int SEL_W  = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             op,
   input  logic [1:0]             addr_mode,
   input  logic [SEL_W-1:0]       src_sel,
   input  logic [NSRC*DATA_W-1:0] src_data,
   input  logic [DATA_W-1:0]      pc,
   input  logic [DATA_W-1:0]      ze_imm,
   input  logic [DATA_W-1:0]      ls_imm,
   input  logic                   sp_load,
   input  logic [DATA_W-1:0]      sp_load_val,
   output logic [DATA_W-1:0]      sp_out,
   output logic                   rd_valid,
   output logic [DATA_W-1:0]      rd_data,
   input  logic                   rd_ready,
   output logic                   fault
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [DATA_W-1:0] SP_RST = DATA_W'(DEPTH);

   op_e               op_c;
   logic              accept, is_read, is_write, op_fault;
   logic [DATA_W-1:0] ea_mode, ea_full, sp_dec, wdata, ram_rdata;
   logic [DATA_W-1:0] sp_p1;
   logic              rd_vld_p1, rd_mask_p1;

   assign op_c      = op_e'(op);
   assign is_read   = (op_c == OP_LOAD) || (op_c == OP_POP);
   assign is_write  = (op_c == OP_STORE) || (op_c == OP_PUSH);
   assign req_ready = reset_n && !(rd_vld_p1 && !rd_ready);
   assign accept    = req_valid && req_ready;
   assign sp_dec    = sp_p1 - DATA_W'(1);

   always_comb begin
      ea_mode = pc;
      unique case (am_e'(addr_mode))
         AM_PC:    ea_mode = pc;
         AM_IMM:   ea_mode = ze_imm;
         AM_SP2:   ea_mode = sp_p1 + DATA_W'(SP_INC2);
         AM_SPIMM: ea_mode = sp_p1 + ls_imm;
      endcase
      ea_full = ea_mode;
      if (op_c == OP_PUSH)     ea_full = sp_dec;
      else if (op_c == OP_POP) ea_full = sp_p1;
   end

   always_comb begin
      wdata = '0;
      for (int k = 0; k < NSRC; k++)
         if (src_sel == SEL_W'(k)) wdata = src_data[k*DATA_W +: DATA_W];
   end

`ifdef MEM_ACCESS_BOUNDS_EN
   logic fault_p1;

   always_comb begin
      unique case (op_c)
         OP_PUSH: op_fault = (sp_p1 == '0);
         OP_POP:  op_fault = (sp_p1 == SP_RST);
         default: op_fault = (ea_full[DATA_W-1:ADDR_W] != '0);
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) fault_p1 <= 1'b0;
      else          fault_p1 <= fault_p1 | (accept & op_fault);
   end

   assign fault = fault_p1;
`else
   // Upper address bits only matter when bounds checking is built in.
   logic unused_ea_hi;
   assign unused_ea_hi = ^ea_full[DATA_W-1:ADDR_W];
   assign op_fault     = 1'b0;
   assign fault        = 1'b0;
`endif

   mem_access_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock (clock),
      .we    (accept && is_write && !op_fault),
      .re    (accept && is_read && !op_fault),
      .addr  (ea_full[ADDR_W-1:0]),
      .wdata (wdata),
      .rdata (ram_rdata)
   );

   // Stage p1: stack pointer and response registers
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sp_p1      <= SP_RST;
         rd_vld_p1  <= 1'b0;
         rd_mask_p1 <= 1'b1;
      end else begin
         if (sp_load)
            sp_p1 <= sp_load_val;
         else if (accept && !op_fault && op_c == OP_PUSH)
            sp_p1 <= sp_dec;
         else if (accept && !op_fault && op_c == OP_POP)
            sp_p1 <= sp_p1 + DATA_W'(1);

         if (accept && is_read) begin
            rd_vld_p1  <= 1'b1;
            rd_mask_p1 <= op_fault;
         end else if (rd_ready) begin
            rd_vld_p1  <= 1'b0;
         end
      end
   end

   // A masked response (reset or faulting read) reads as zero.
   assign rd_data  = rd_mask_p1 ? '0 : ram_rdata;
   assign rd_valid = rd_vld_p1;
   assign sp_out   = sp_p1;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed steps plus a randomized
// phase against a word-array/stack reference model.
module tb_mem_access_unit;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 10;
   localparam int NSRC   = 3;
   localparam int SEL_W  = 2;
   localparam int DEPTH  = 1 << ADDR_W;
`ifdef MEM_ACCESS_BOUNDS_EN
   localparam bit BOUNDS = 1'b1;
`else
   localparam bit BOUNDS = 1'b0;
`endif

   logic                   clock = 1'b0;
   logic                   reset_n;
   logic                   req_valid;
   logic                   req_ready;
   logic [1:0]             op;
   logic [1:0]             addr_mode;
   logic [SEL_W-1:0]       src_sel;
   logic [NSRC*DATA_W-1:0] src_data;
   logic [DATA_W-1:0]      pc, ze_imm, ls_imm;
   logic                   sp_load;
   logic [DATA_W-1:0]      sp_load_val;
   logic [DATA_W-1:0]      sp_out;
   logic                   rd_valid;
   logic [DATA_W-1:0]      rd_data;
   logic                   rd_ready;
   logic                   fault;

   always #5 clock = ~clock;

   mem_access_unit #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NSRC   (NSRC)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .op          (op),
      .addr_mode   (addr_mode),
      .src_sel     (src_sel),
      .src_data    (src_data),
      .pc          (pc),
      .ze_imm      (ze_imm),
      .ls_imm      (ls_imm),
      .sp_load     (sp_load),
      .sp_load_val (sp_load_val),
      .sp_out      (sp_out),
      .rd_valid    (rd_valid),
      .rd_data     (rd_data),
      .rd_ready    (rd_ready),
      .fault       (fault)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state
   logic [DATA_W-1:0] mem_m [DEPTH];
   logic [DATA_W-1:0] sp_m;
   logic [DATA_W-1:0] rdd_m;
   logic              rdv_m;
   logic              fault_m;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rd_valid"},  32'(rd_valid),  32'(rdv_m));
      check({tag, ".rd_data"},   32'(rd_data),   32'(rdd_m));
      check({tag, ".sp_out"},    32'(sp_out),    32'(sp_m));
      check({tag, ".fault"},     32'(fault),     32'(fault_m));
      check({tag, ".req_ready"}, 32'(req_ready), 32'(!(rdv_m && !rd_ready)));
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = 1'b0;
      sp_load   = 1'b0;
      rd_ready  = 1'b1;
      @(posedge clock); #1;
      sp_m = DATA_W'(DEPTH); rdv_m = 1'b0; rdd_m = '0; fault_m = 1'b0;
      check("rst.rd_valid",  32'(rd_valid),  32'd0);
      check("rst.rd_data",   32'(rd_data),   32'd0);
      check("rst.sp_out",    32'(sp_out),    32'(DEPTH));
      check("rst.fault",     32'(fault),     32'd0);
      check("rst.req_ready", 32'(req_ready), 32'd0);
      reset_n = 1'b1;
      #1;
      check("rst.ready_after", 32'(req_ready), 32'd1);
   endtask

   // One clock of stimulus; the model applies the spec rules at the same edge.
   task automatic step(input string tag, input logic v, input logic [1:0] o,
                       input logic [1:0] am, input int sel, input logic [DATA_W-1:0] d,
                       input logic [DATA_W-1:0] pcv, input logic [DATA_W-1:0] immv,
                       input logic [DATA_W-1:0] lsv, input logic spl,
                       input logic [DATA_W-1:0] splv, input logic rr);
      logic [DATA_W-1:0] ea;
      bit flt, acc, rdop;
      int idx;
      req_valid = v; op = o; addr_mode = am; src_sel = sel[SEL_W-1:0];
      src_data = {16'($urandom), 16'($urandom), 16'($urandom)};
      src_data[sel*DATA_W +: DATA_W] = d;
      pc = pcv; ze_imm = immv; ls_imm = lsv;
      sp_load = spl; sp_load_val = splv; rd_ready = rr;

      acc  = v && !(rdv_m && !rr);
      rdop = (o == 2'd0) || (o == 2'd3);
      case (o)
         2'd2:    begin ea = sp_m - 16'd1; flt = BOUNDS && (sp_m == 16'd0); end
         2'd3:    begin ea = sp_m;         flt = BOUNDS && (sp_m == 16'(DEPTH)); end
         default: begin
            case (am)
               2'd0:    ea = pcv;
               2'd1:    ea = immv;
               2'd2:    ea = sp_m + 16'd2;
               default: ea = sp_m + lsv;
            endcase
            flt = BOUNDS && (int'(ea) >= DEPTH);
         end
      endcase
      idx = int'(ea) % DEPTH;

      @(posedge clock);
      if (acc) begin
         if (rdop)      rdd_m = flt ? '0 : mem_m[idx];
         else if (!flt) mem_m[idx] = d;
         if (flt) fault_m = 1'b1;
      end
      if (spl)                               sp_m = splv;
      else if (acc && !flt && o == 2'd2)     sp_m = sp_m - 16'd1;
      else if (acc && !flt && o == 2'd3)     sp_m = sp_m + 16'd1;
      if (acc && rdop) rdv_m = 1'b1;
      else if (rr)     rdv_m = 1'b0;
      #1;
      req_valid = 1'b0;
      sp_load   = 1'b0;
      check_all(tag);
   endtask

   task automatic store_imm(input int sel, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] a);
      step("st", 1'b1, 2'd1, 2'd1, sel, d, '0, a, '0, 1'b0, '0, 1'b1);
   endtask

   task automatic load_imm(input logic [DATA_W-1:0] a);
      step("ld", 1'b1, 2'd0, 2'd1, 0, '0, '0, a, '0, 1'b0, '0, 1'b1);
   endtask

   task automatic idle(input logic rr);
      step("idle", 1'b0, 2'd0, 2'd0, 0, '0, '0, '0, '0, 1'b0, '0, rr);
   endtask

   initial begin
      logic [DATA_W-1:0] held;
      reset_n = 1'b1; req_valid = 1'b0; op = '0; addr_mode = '0; src_sel = '0;
      src_data = '0; pc = '0; ze_imm = '0; ls_imm = '0; sp_load = 1'b0;
      sp_load_val = '0; rd_ready = 1'b1;
      do_reset();

      // Fill memory so every model word is known.
      for (int i = 0; i < DEPTH; i++) store_imm(i % NSRC, 16'($urandom), 16'(i));

      // Store / load through each source channel
      store_imm(0, 16'd1, 16'd0); load_imm(16'd0); check("ld0", 32'(rd_data), 32'd1);
      store_imm(1, 16'd2, 16'd1); load_imm(16'd1); check("ld1", 32'(rd_data), 32'd2);
      store_imm(2, 16'd3, 16'd2); load_imm(16'd2); check("ld2", 32'(rd_data), 32'd3);

      // Address modes: pc, sp+2, sp+ls_imm
      step("st_pc", 1'b1, 2'd1, 2'd0, 0, 16'd4, 16'd3, '0, '0, 1'b0, '0, 1'b1);
      step("spl2",  1'b0, 2'd0, 2'd0, 0, '0, '0, '0, '0, 1'b1, 16'd2, 1'b1);
      step("st_sp2", 1'b1, 2'd1, 2'd2, 0, 16'd5, '0, '0, '0, 1'b0, '0, 1'b1);
      step("spl1",  1'b0, 2'd0, 2'd0, 0, '0, '0, '0, '0, 1'b1, 16'd1, 1'b1);
      step("st_spi", 1'b1, 2'd1, 2'd3, 1, 16'd6, '0, '0, 16'd4, 1'b0, '0, 1'b1);
      for (int a = 0; a < 6; a++) begin
         load_imm(16'(a));
         check("integrity", 32'(rd_data), 32'(a + 1));
      end

      // Stack push / pop
      do_reset();
      step("push_a", 1'b1, 2'd2, 2'd0, 0, 16'hAAAA, '0, '0, '0, 1'b0, '0, 1'b1);
      step("push_b", 1'b1, 2'd2, 2'd0, 1, 16'hBBBB, '0, '0, '0, 1'b0, '0, 1'b1);
      check("sp_two", 32'(sp_out), 32'(DEPTH - 2));
      step("pop_b", 1'b1, 2'd3, 2'd0, 0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
      check("pop_b_val", 32'(rd_data), 32'hBBBB);
      step("pop_a", 1'b1, 2'd3, 2'd0, 0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
      check("pop_a_val", 32'(rd_data), 32'hAAAA);
      check("sp_empty", 32'(sp_out), 32'(DEPTH));
      // Push with coincident sp_load: old sp addresses, loaded value wins.
      step("push_spl", 1'b1, 2'd2, 2'd0, 2, 16'h1234, '0, '0, '0, 1'b1, 16'd100, 1'b1);
      load_imm(16'(DEPTH - 1));
      check("push_spl_val", 32'(rd_data), 32'h1234);

      // Backpressure: response held, requests refused, then released.
      load_imm(16'd3);
      held = rd_data;
      step("stall1", 1'b1, 2'd1, 2'd1, 0, 16'hDEAD, '0, 16'd3, '0, 1'b0, '0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      check("stall_data", 32'(rd_data), 32'(held));
      check("stall_rdy",  32'(req_ready), 32'd0);
      idle(1'b1);
      check("release_rdy", 32'(req_ready), 32'd1);
      for (int a = 0; a < 4; a++) load_imm(16'(a));

      // Boundary behaviour (fault with checks built in, wrap otherwise)
      do_reset();
      step("pop_empty", 1'b1, 2'd3, 2'd0, 0, '0, '0, '0, '0, 1'b0, '0, 1'b1);
      load_imm(16'(DEPTH));
      step("spl0", 1'b0, 2'd0, 2'd0, 0, '0, '0, '0, '0, 1'b1, 16'd0, 1'b1);
      step("push_full", 1'b1, 2'd2, 2'd0, 0, 16'h5555, '0, '0, '0, 1'b0, '0, 1'b1);
      load_imm(16'(DEPTH - 1));

      // Reset while a response is pending
      load_imm(16'd1);
      step("pend", 1'b1, 2'd0, 2'd1, 0, '0, '0, 16'd2, '0, 1'b0, '0, 1'b0);
      do_reset();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [1:0]        ro, ram;
         logic [DATA_W-1:0] raddr;
         logic              rspl;
         ro    = 2'($urandom);
         ram   = 2'($urandom);
         raddr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
         rspl  = ($urandom_range(0, 15) == 0);
         step("rand", 1'($urandom_range(0, 3) != 0), ro, ram, $urandom_range(0, NSRC - 1),
              16'($urandom), raddr, 16'($urandom_range(0, DEPTH)), 16'($urandom_range(0, 8)),
              rspl, 16'($urandom_range(0, DEPTH + 1)), 1'($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised data-memory access unit for the processor's memory stage. It is the successor to the fixed 16-bit memory datapath and generalises data width, memory depth and the number of register-file source channels. It adds an internal stack pointer with push/pop, a valid/ready request handshake, and a registered read response with backpressure. It sits between the register file and the writeback mux.

## Interface
Parameters:
- DATA_W, 16, word width; also the width of pc, imm and sp
- ADDR_W, 10, word-address width; DEPTH = 2**ADDR_W; must satisfy ADDR_W < DATA_W
- NSRC, 3, number of store-data source channels (Mary, Shelley, RA by default)

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- op  in  2  00 load, 01 store, 10 push, 11 pop
- addr_mode  in  2  00 pc, 01 ze_imm, 10 sp+2, 11 sp+ls_imm; ignored for push/pop
- src_sel  in  max(1,$clog2(NSRC))  store/push data channel
- src_data  in  NSRC*DATA_W  packed source words; channel k occupies bits [k*DATA_W +: DATA_W]
- pc, ze_imm, ls_imm  in  DATA_W each  address operands
- sp_load  in  1  overwrite the stack pointer
- sp_load_val  in  DATA_W  new stack pointer value
- sp_out  out  DATA_W  current stack pointer
- rd_valid  out  1  read response valid
- rd_data  out  DATA_W  read response data
- rd_ready  in  1  consumer accepts the response
- fault  out  1  sticky access fault

## Operation
- Accept: a request is taken on a clock edge where req_valid && req_ready.
- req_ready = reset_n && !(rd_valid && !rd_ready). At most one read response is outstanding.
- Effective address:
  - Full DATA_W sum of the operands selected by addr_mode; sp+2 adds literal 2.
  - RAM index = low ADDR_W bits of that sum.
- Store: mem[ea] <= src_data[src_sel]. No response is produced.
- Load: mem[ea] is read on the accept edge. rd_data/rd_valid are registered.
- Stack: sp points to the last pushed word and the stack grows down. Reset sp = DEPTH, which means empty.
  - Push: writes mem[sp-1] and sets sp <= sp-1.
  - Pop: reads mem[sp] and sets sp <= sp+1; it produces a response like a load.
- sp arithmetic is modulo 2**DATA_W.
- sp_load: sp <= sp_load_val. If sp_load coincides with an accepted push/pop:
  - The op addresses memory with the old sp.
  - sp_load_val wins the sp update.
- Store followed by load to the same address on the next accepted cycle returns the new data (write-first ordering across edges).
- RAM contents are not reset.
- Reset values: req_ready 0 while reset_n=0, 1 on the first cycle after; rd_valid 0, rd_data 0, sp_out DEPTH, fault 0.
- Reset mid-response: rd_valid clears and the response is lost.

## Timing
- Load/pop accepted at edge N: rd_valid=1 and rd_data valid from edge N through to the edge where rd_valid && rd_ready.
- Response held stable while rd_ready=0. req_ready drops in that window.
- With rd_ready tied 1, throughput is one request per cycle of any type, back-to-back.
- Store/push take effect at the accept edge. A load accepted the following cycle observes them.
- Response completing and a new load accepted on the same edge: rd_valid stays 1 with new data.

## Configuration
- MEM_ACCESS_BOUNDS_EN defined:
  - Fault conditions:
    - Load/store whose full effective-address sum is ≥ DEPTH.
    - Push with sp==0 (overflow).
    - Pop with sp==DEPTH (underflow).
  - A faulting op is still accepted but has no RAM write and no sp change.
  - A faulting load/pop returns rd_data=0 with normal handshake.
  - fault is set and held until reset.
- MEM_ACCESS_BOUNDS_EN undefined:
  - No checks; addresses wrap modulo DEPTH.
  - fault tied 0.

## Structure
- Package mem_access_pkg:
  - op codes (OP_LOAD, OP_STORE, OP_PUSH, OP_POP)
  - addr_mode codes (AM_PC, AM_IMM, AM_SP2, AM_SPIMM)
  - the sp+2 constant
- Sub-module mem_access_ram:
  - single-port synchronous RAM, DATA_W x DEPTH
  - one write enable, registered read
- Top level contains address mux, sp register, response register/handshake and fault logic.

## Test plan
- Store ch0=1 at ze_imm=0, then load ze_imm=0 -> rd_valid next cycle, rd_data=1; repeat for ch1=2@1 and ch2=3@2.
- Store ch0=4 via pc=3; store ch0=5 via sp_load 2 + sp+2; store ch1=6 via sp=1, ls_imm=4 -> loads at 3, 4, 5 return 4, 5, 6; memory integrity: addresses 0..5 read back 1..6.
- After reset, push 0xAAAA then 0xBBBB -> sp_out DEPTH-2; pop, pop -> rd_data 0xBBBB then 0xAAAA, sp_out DEPTH.
- Load with rd_ready=0 for 3 cycles -> rd_data/rd_valid stable, req_ready=0; rd_ready=1 -> req_ready=1 next cycle; back-to-back loads with rd_ready=1 -> one response per cycle.
- MEM_ACCESS_BOUNDS_EN: pop at reset -> rd_data 0, fault=1, sp_out unchanged; load ze_imm=DEPTH -> fault; without the macro the same load returns mem[0].
- Assert reset_n=0 while a response is pending -> rd_valid 0, sp_out DEPTH, fault 0 on the next edge.
